// File: rtl/mdr_pkg.sv
// Shared op codes and FSM state encoding for the memory data register controller.
package mdr_pkg;

    typedef enum logic [1:0] {
        MDR_NOP  = 2'b00,
        MDR_LDR  = 2'b01,
        MDR_STR  = 2'b10,
        MDR_LDRB = 2'b11
    } mdr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } mdr_state_e;

endpackage

// File: rtl/mdr_load_fmt.sv
// Load-data formatter: word passthrough, or byte select with zero/sign extension.
module mdr_load_fmt
    import mdr_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] rdata,
    input  mdr_op_e           op,
    input  logic              sext,
    input  logic              addr_lsb,
    output logic [DATA_W-1:0] ldata
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = addr_lsb ? rdata[15:8] : rdata[7:0];
        ldata    = rdata;
        if (op == MDR_LDRB) begin
            ldata = {{(DATA_W - 8){sext & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mdr_ctrl.sv
// Memory data register: accepts load/store ops, runs a req/ack RAM access
// with optional timeout, and holds the last load result.
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 16,
    parameter int unsigned       TIMEOUT = 15,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_reg2mdr,
    output logic              op_ready,
    output logic [DATA_W-1:0] data_mdr2reg,
    output logic              done,
    output logic              err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned      LAST_IDX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_IDX);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mdr_state_e        state_q, state_d;
    mdr_op_e           op_q, op_d;
    mdr_op_e           op_in;
    logic              sext_q, sext_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ldata;

    assign op_in = mdr_op_e'(op);

    mdr_load_fmt #(
        .DATA_W (DATA_W)
    ) u_load_fmt (
        .rdata    (ram_rdata),
        .op       (op_q),
        .sext     (sext_q),
        .addr_lsb (addr_q[0]),
        .ldata    (ldata)
    );

    // Next state and registered-output decode (outputs follow the next state).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sext_d  = sext_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (op_valid && (op_in != MDR_NOP)) begin
                    op_d    = op_in;
                    sext_d  = sext;
                    addr_d  = addr_in;
                    cnt_d   = '0;
                    state_d = REQ;
                    if (op_in == MDR_STR) begin
                        wdata_d = data_reg2mdr;
                    end
                end
            end
            REQ: begin
                if (ram_ack) begin
                    if (op_q != MDR_STR) begin
                        data_d = ldata;
                    end
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        req_d   = (state_d == REQ);
        we_d    = (state_d == REQ) && (op_d == MDR_STR);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= MDR_NOP;
            sext_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= RST_VAL;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sext_q  <= sext_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign op_ready     = ready_q;
    assign data_mdr2reg = data_q;
    assign done         = done_q;
    assign err          = err_q;
    assign ram_req      = req_q;
    assign ram_we       = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;

endmodule

// File: tb/tb_mdr_ctrl.sv
// Bench for mdr_ctrl: directed scenarios plus randomized accesses against a
// transaction-level reference model of the load register.
module tb_mdr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        sext;
    logic [15:0] addr_in;
    logic [15:0] data_reg2mdr;
    logic        op_ready;
    logic [15:0] data_mdr2reg;
    logic        done;
    logic        err;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] mdl_data;
    logic [15:0] mdl_wdata;

    mdr_ctrl #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .TIMEOUT (15),
        .RST_VAL (16'h0001)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .sext         (sext),
        .addr_in      (addr_in),
        .data_reg2mdr (data_reg2mdr),
        .op_ready     (op_ready),
        .data_mdr2reg (data_mdr2reg),
        .done         (done),
        .err          (err),
        .ram_req      (ram_req),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_ack      (ram_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result a load leaves in the data register, from the op rules alone.
    function automatic logic [15:0] exp_load(input logic [1:0] o, input logic sx, input logic lsb,
                                             input logic [15:0] rd, input logic [15:0] old);
        int b;
        if (o == 2'b01) return rd;
        if (o != 2'b11) return old;
        b = lsb ? int'(rd) / 256 : int'(rd) % 256;
        if (sx && b >= 128) return 16'(b + 65280);
        return 16'(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access; ack arrives in REQ cycle index 'waits' (-1 = never).
    task automatic run_access(input logic [1:0] o, input logic sx, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] rd, input int waits,
                              output int done_cyc, output int err_cyc, output int req_cnt,
                              output logic side_bad);
        done_cyc = -1;
        err_cyc  = -1;
        req_cnt  = 0;
        side_bad = 1'b0;
        for (int i = 0; i < 6 && !op_ready; i++) step();
        op_valid     = 1'b1;
        op           = o;
        sext         = sx;
        addr_in      = a;
        data_reg2mdr = wd;
        step();
        op_valid     = 1'b0;
        op           = 2'b00;
        addr_in      = 16'($urandom);
        data_reg2mdr = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (done) begin done_cyc = c; break; end
            if (err)  begin err_cyc = c;  break; end
            ram_ack = 1'b0;
            if (ram_req) begin
                if (ram_we !== (o == 2'b10) || ram_addr !== a || op_ready !== 1'b0) side_bad = 1'b1;
                if (o == 2'b10 && ram_wdata !== wd) side_bad = 1'b1;
                ram_ack   = (req_cnt == waits);
                ram_rdata = (req_cnt == waits) ? rd : 16'($urandom);
                req_cnt++;
            end else begin
                side_bad = 1'b1;
            end
            step();
        end
        ram_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++; if (data_mdr2reg !== 16'h0001) begin n_fail++; $display("FAIL reset_data: got %h expected 0001", data_mdr2reg); end
        n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
        n_cmp++; if ({ram_req, ram_we, done, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {ram_req, ram_we, done, err}); end
        n_cmp++; if ({ram_addr, ram_wdata} !== 32'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h expected 00000000", {ram_addr, ram_wdata}); end
        @(negedge clk);
        rst = 1'b1;
        step();
        op_valid = 1'b1; op = 2'b01; sext = 1'b0; addr_in = 16'h0222; data_reg2mdr = 16'h0;
        step();
        op_valid = 1'b0;
        n_cmp++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL reset_pre_req: got %b expected 1", ram_req); end
        step();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_midreq_req: got %b expected 0", ram_req); end
        n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_midreq_ready: got %b expected 1", op_ready); end
        n_cmp++; if (data_mdr2reg !== 16'h0001) begin n_fail++; $display("FAIL reset_midreq_data: got %h expected 0001", data_mdr2reg); end
        @(negedge clk);
        rst = 1'b1;
        ram_ack = 1'b1;
        ram_rdata = 16'hDEAD;
        begin
            int spurious = 0;
            for (int i = 0; i < 4; i++) begin step(); if (done || err || ram_req) spurious++; end
            n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL reset_lost_access: got %0d events expected 0", spurious); end
        end
        ram_ack = 1'b0;
        mdl_data = 16'h0001;
        mdl_wdata = 16'h0000;
    endtask

    task automatic test_ldr();
        int dc, ec, rc; logic sb;
        run_access(2'b01, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 3, dc, ec, rc, sb);
        mdl_data = 16'hBEEF;
        n_cmp++; if (dc !== 5) begin n_fail++; $display("FAIL ldr_done_cycle: got %0d expected 5", dc); end
        n_cmp++; if (ec !== -1) begin n_fail++; $display("FAIL ldr_no_err: got %0d expected -1", ec); end
        n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL ldr_data: got %h expected %h", data_mdr2reg, mdl_data); end
        n_cmp++; if (sb !== 1'b0) begin n_fail++; $display("FAIL ldr_bus_signals: got %b expected 0", sb); end
    endtask

    task automatic test_str();
        int dc, ec, rc; logic sb;
        run_access(2'b10, 1'b0, 16'h0010, 16'h1234, 16'h5555, 0, dc, ec, rc, sb);
        mdl_wdata = 16'h1234;
        n_cmp++; if (dc !== 2) begin n_fail++; $display("FAIL str_done_cycle: got %0d expected 2", dc); end
        n_cmp++; if (sb !== 1'b0) begin n_fail++; $display("FAIL str_bus_signals: got %b expected 0", sb); end
        n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL str_data_held: got %h expected %h", data_mdr2reg, mdl_data); end
        n_cmp++; if (ram_wdata !== mdl_wdata) begin n_fail++; $display("FAIL str_wdata: got %h expected %h", ram_wdata, mdl_wdata); end
    endtask

    task automatic test_ldrb();
        int dc, ec, rc; logic sb;
        run_access(2'b11, 1'b1, 16'h0031, 16'h0, 16'h80F5, 1, dc, ec, rc, sb);
        n_cmp++; if (data_mdr2reg !== 16'hFF80) begin n_fail++; $display("FAIL ldrb_hi_sext: got %h expected ff80", data_mdr2reg); end
        run_access(2'b11, 1'b0, 16'h0030, 16'h0, 16'h80F5, 0, dc, ec, rc, sb);
        n_cmp++; if (data_mdr2reg !== 16'h00F5) begin n_fail++; $display("FAIL ldrb_lo_zext: got %h expected 00f5", data_mdr2reg); end
        n_cmp++; if (dc !== 2 || sb !== 1'b0) begin n_fail++; $display("FAIL ldrb_timing: got cycle %0d bad %b expected 2/0", dc, sb); end
        mdl_data = 16'h00F5;
    endtask

    task automatic test_timeout();
        int dc, ec, rc; logic sb;
        run_access(2'b01, 1'b0, 16'h0077, 16'h0, 16'h9999, -1, dc, ec, rc, sb);
        n_cmp++; if (ec !== 16) begin n_fail++; $display("FAIL timeout_err_cycle: got %0d expected 16", ec); end
        n_cmp++; if (rc !== 15) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 15", rc); end
        n_cmp++; if (dc !== -1) begin n_fail++; $display("FAIL timeout_no_done: got %0d expected -1", dc); end
        n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL timeout_data_held: got %h expected %h", data_mdr2reg, mdl_data); end
        step();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err); end
        run_access(2'b01, 1'b0, 16'h0078, 16'h0, 16'h4321, 14, dc, ec, rc, sb);
        mdl_data = 16'h4321;
        n_cmp++; if (dc !== 16 || ec !== -1) begin n_fail++; $display("FAIL ack_last_cycle: got done %0d err %0d expected 16/-1", dc, ec); end
        n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL ack_last_data: got %h expected %h", data_mdr2reg, mdl_data); end
    endtask

    task automatic test_busy_hold();
        int   dn = 0, rises = 0, bad = 0;
        logic prev_req = 1'b0;
        op_valid = 1'b1; op = 2'b01; sext = 1'b0; addr_in = 16'h0101; data_reg2mdr = 16'h0;
        ram_rdata = 16'hA5C3;
        step();
        for (int c = 0; c < 10; c++) begin
            if (ram_req && !prev_req) rises++;
            prev_req = ram_req;
            if (done) begin dn++; op_valid = 1'b0; end
            ram_ack = ram_req;
            step();
        end
        ram_ack = 1'b0;
        mdl_data = 16'hA5C3;
        n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", dn); end
        n_cmp++; if (rises !== 1) begin n_fail++; $display("FAIL busy_access_count: got %0d expected 1", rises); end
        n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL busy_data: got %h expected %h", data_mdr2reg, mdl_data); end
        op_valid = 1'b1; op = 2'b00; ram_ack = 1'b1; ram_rdata = 16'h1111;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done || err || ram_req || !op_ready) bad++;
        end
        op_valid = 1'b0; ram_ack = 1'b0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL nop_stray_ack_events: got %0d expected 0", bad); end
        n_cmp++; if (data_mdr2reg !== mdl_data || ram_wdata !== mdl_wdata) begin n_fail++; $display("FAIL nop_outputs_held: got %h/%h expected %h/%h", data_mdr2reg, ram_wdata, mdl_data, mdl_wdata); end
    endtask

    task automatic test_random();
        int dc, ec, rc, waits, exp_dc, exp_ec; logic sb;
        logic [1:0] o; logic sx; logic [15:0] a, wd, rd;
        for (int i = 0; i < 24; i++) begin
            o  = 2'($urandom_range(3, 1));
            sx = 1'($urandom);
            a  = 16'($urandom);
            wd = 16'($urandom);
            rd = 16'($urandom);
            waits = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(5));
            run_access(o, sx, a, wd, rd, waits, dc, ec, rc, sb);
            exp_dc = (waits >= 0) ? waits + 2 : -1;
            exp_ec = (waits >= 0) ? -1 : 16;
            if (waits >= 0) mdl_data = exp_load(o, sx, a[0], rd, mdl_data);
            if (o == 2'b10) mdl_wdata = wd;
            n_cmp++; if (dc !== exp_dc || ec !== exp_ec) begin n_fail++; $display("FAIL rand_timing[%0d]: got done %0d err %0d expected %0d/%0d", i, dc, ec, exp_dc, exp_ec); end
            n_cmp++; if (data_mdr2reg !== mdl_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h (op %0d)", i, data_mdr2reg, mdl_data, o); end
            n_cmp++; if (ram_wdata !== mdl_wdata || ram_addr !== a || sb !== 1'b0) begin n_fail++; $display("FAIL rand_bus[%0d]: got wdata %h addr %h bad %b expected %h %h 0", i, ram_wdata, ram_addr, sb, mdl_wdata, a); end
        end
    endtask

    initial begin
        op_valid = 1'b0; op = 2'b00; sext = 1'b0; addr_in = '0; data_reg2mdr = '0;
        ram_rdata = '0; ram_ack = 1'b0;
        mdl_data = 16'h0001; mdl_wdata = 16'h0000;
        test_reset();
        test_ldr();
        test_str();
        test_ldrb();
        test_timeout();
        test_busy_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
